// File: rtl/ddr3_rd_checker.sv
// Read-back checker: compares MIG read beats against a seeded incrementing pattern, lane by lane.
// Latency: results and state update on the edge that samples each beat; done rises one edge after the last beat.
// Backpressure: none; one beat accepted on every cycle app_rd_data_valid is high.
module ddr3_rd_checker #(
    parameter int BEATS       = 8,
    parameter int TIMEOUT_CYC = 4096,
    parameter int LANES       = 16
) (
    input  logic                  ui_clk,
    input  logic                  ui_rst_n,
    input  logic                  start,
    input  logic [31:0]           seed,
    input  logic                  app_rd_data_valid,
    input  logic [32*LANES-1:0]   app_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           err_cnt,
    output logic [7:0]            first_err_beat,
    output logic [LANES-1:0]      first_err_mask
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        CHECK = 3'b010,
        DONE  = 3'b100
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        seed_q, seed_d;
    logic [7:0]         beat_q, beat_d;
    logic [TW-1:0]      to_q, to_d;
    logic [15:0]        err_q, err_d;
    logic [7:0]         feb_q, feb_d;
    logic [LANES-1:0]   fem_q, fem_d;
    logic               pass_q, pass_d;
    logic               tmo_q, tmo_d;

    logic [LANES-1:0]   mism;
    logic               beat_bad;

    // Lane i of beat k is expected to hold seed + LANES*k + i (mod 2^32).
    always_comb begin
        mism = '0;
        for (int i = 0; i < LANES; i++) begin
            mism[i] = app_rd_data[32*i +: 32] !=
                      (seed_q + 32'(beat_q) * 32'(LANES) + 32'(i));
        end
    end

    assign beat_bad = |mism;

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        beat_d  = beat_q;
        to_d    = to_q;
        err_d   = err_q;
        feb_d   = feb_q;
        fem_d   = fem_q;
        pass_d  = pass_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CHECK;
                    seed_d  = seed;
                    beat_d  = '0;
                    to_d    = '0;
                    err_d   = '0;
                    feb_d   = '0;
                    fem_d   = '0;
                    pass_d  = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            CHECK: begin
                if (app_rd_data_valid) begin
                    beat_d = beat_q + 8'd1;
                    to_d   = '0;
                    if (beat_bad) begin
                        err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                        // err_cnt never returns to zero within a run, so zero marks "no mismatch yet".
                        if (err_q == 16'h0000) begin
                            feb_d = beat_q;
                            fem_d = mism;
                        end
                    end
                    if (beat_q == 8'(BEATS - 1)) begin
                        state_d = DONE;
                        pass_d  = (err_q == 16'h0000) && !beat_bad;
                    end
                end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                    pass_d  = 1'b0;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            state_q <= IDLE;
            seed_q  <= '0;
            beat_q  <= '0;
            to_q    <= '0;
            err_q   <= '0;
            feb_q   <= '0;
            fem_q   <= '0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            beat_q  <= beat_d;
            to_q    <= to_d;
            err_q   <= err_d;
            feb_q   <= feb_d;
            fem_q   <= fem_d;
            pass_q  <= pass_d;
            tmo_q   <= tmo_d;
        end
    end

    assign busy           = (state_q == CHECK);
    assign done           = (state_q == DONE);
    assign pass           = pass_q;
    assign timeout        = tmo_q;
    assign err_cnt        = err_q;
    assign first_err_beat = feb_q;
    assign first_err_mask = fem_q;

endmodule

// File: tb/tb_ddr3_rd_checker.sv
// Scoreboard bench for ddr3_rd_checker: directed runs push hand-computed results, a monitor checks them when done rises.
module tb_ddr3_rd_checker;

    localparam int BEATS = 8;
    localparam int TMO   = 16;
    localparam int LANES = 16;

    logic               ui_clk = 1'b0;
    logic               ui_rst_n = 1'b0;
    logic               start = 1'b0;
    logic [31:0]        seed = '0;
    logic               vld = 1'b0;
    logic [511:0]       dat = '0;
    logic               busy, done, pass, timeout;
    logic [15:0]        err_cnt;
    logic [7:0]         first_err_beat;
    logic [15:0]        first_err_mask;

    ddr3_rd_checker #(.BEATS(BEATS), .TIMEOUT_CYC(TMO), .LANES(LANES)) dut (
        .ui_clk            (ui_clk),
        .ui_rst_n          (ui_rst_n),
        .start             (start),
        .seed              (seed),
        .app_rd_data_valid (vld),
        .app_rd_data       (dat),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .timeout           (timeout),
        .err_cnt           (err_cnt),
        .first_err_beat    (first_err_beat),
        .first_err_mask    (first_err_mask)
    );

    always #5 ui_clk = ~ui_clk;

    int cyc = 0;
    always @(posedge ui_clk) cyc <= cyc + 1;

    typedef struct {
        logic        p;
        logic        t;
        logic [15:0] e;
        logic [7:0]  fb;
        logic [15:0] fm;
        int          dc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per rising edge of done.
    logic done_d = 1'b0;
    always @(negedge ui_clk) begin
        exp_t e;
        if (ui_rst_n && done && !done_d) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 at cyc %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("pass", {31'd0, pass}, {31'd0, e.p});
                chk("timeout", {31'd0, timeout}, {31'd0, e.t});
                chk("err_cnt", {16'd0, err_cnt}, {16'd0, e.e});
                chk("first_err_beat", {24'd0, first_err_beat}, {24'd0, e.fb});
                chk("first_err_mask", {16'd0, first_err_mask}, {16'd0, e.fm});
                chk("done_cycle", cyc, e.dc);
            end
        end
        done_d = done;
    end

    function automatic logic [511:0] gen_beat(input logic [31:0] s, input int k);
        logic [511:0] b;
        for (int i = 0; i < LANES; i++) b[32*i +: 32] = s + 32'(16*k + i);
        return b;
    endfunction

    task automatic do_start(input logic [31:0] s);
        seed  = s;
        start = 1'b1;
        @(negedge ui_clk);
        start = 1'b0;
        seed  = 32'hCAFE_F00D;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge ui_clk);
            n++;
        end
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic run(input logic [31:0] s, input int nb, input int gap,
                       input int ea, input logic [511:0] xa,
                       input int eb, input logic [511:0] xb,
                       input bit midstart, input bit tmo, input exp_t e);
        logic [511:0] d;
        do_start(s);
        for (int k = 0; k < nb; k++) begin
            if (midstart && k == 4) begin
                seed  = 32'hDEAD_BEEF;
                start = 1'b1;
                @(negedge ui_clk);
                start = 1'b0;
            end
            d = gen_beat(s, k);
            if (k == ea) d = d ^ xa;
            if (k == eb) d = d ^ xb;
            if (k == nb - 1) begin
                e.dc = tmo ? cyc + 1 + TMO : cyc + 1;
                sb.push_back(e);
            end
            dat = d;
            vld = 1'b1;
            @(negedge ui_clk);
            vld = 1'b0;
            dat = '0;
            repeat (gap) @(negedge ui_clk);
        end
        wait_done(200);
    endtask

    task automatic stray_beats(input int n);
        for (int i = 0; i < n; i++) begin
            dat = {16{$urandom}};
            vld = 1'b1;
            @(negedge ui_clk);
        end
        vld = 1'b0;
        dat = '0;
    endtask

    logic [511:0] ones;
    logic [511:0] lane5;

    initial begin
        ones  = '1;
        lane5 = '0;
        lane5[160] = 1'b1;

        repeat (2) @(negedge ui_clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        chk("rst_first_err_beat", {24'd0, first_err_beat}, 32'd0);
        chk("rst_first_err_mask", {16'd0, first_err_mask}, 32'd0);
        ui_rst_n = 1'b1;
        @(negedge ui_clk);

        stray_beats(3);
        chk("idle_stray_busy", {31'd0, busy}, 32'd0);
        chk("idle_stray_err", {16'd0, err_cnt}, 32'd0);

        // Clean back-to-back run
        run(32'h0000_0000, 8, 0, -1, '0, -1, '0, 1'b0, 1'b0,
            '{p: 1'b1, t: 1'b0, e: 16'd0, fb: 8'd0, fm: 16'h0000, dc: 0});
        // Beat 3 lane 5 bit 0 flipped
        run(32'h1000_0000, 8, 0, 3, lane5, -1, '0, 1'b0, 1'b0,
            '{p: 1'b0, t: 1'b0, e: 16'd1, fb: 8'd3, fm: 16'h0020, dc: 0});

        stray_beats(3);
        chk("done_stray_err", {16'd0, err_cnt}, 32'd1);
        chk("done_stray_beat", {24'd0, first_err_beat}, 32'd3);
        chk("done_stray_mask", {16'd0, first_err_mask}, 32'h0020);
        chk("done_stray_done", {31'd0, done}, 32'd1);
        chk("done_stray_pass", {31'd0, pass}, 32'd0);

        // Beats 2 and 6 inverted, with a start pulse mid-run that must be ignored
        run(32'h1234_5678, 8, 0, 2, ones, 6, ones, 1'b1, 1'b0,
            '{p: 1'b0, t: 1'b0, e: 16'd2, fb: 8'd2, fm: 16'hFFFF, dc: 0});
        // 4 beats with 3-cycle gaps then silence -> timeout
        run(32'hA5A5_0000, 4, 3, -1, '0, -1, '0, 1'b0, 1'b1,
            '{p: 1'b0, t: 1'b1, e: 16'd0, fb: 8'd0, fm: 16'h0000, dc: 0});
        // 15-cycle gaps are just inside the limit
        run(32'h0F0F_0F0F, 8, 15, -1, '0, -1, '0, 1'b0, 1'b0,
            '{p: 1'b1, t: 1'b0, e: 16'd0, fb: 8'd0, fm: 16'h0000, dc: 0});
        // Pattern wraps through zero at beat 0 lane 8
        run(32'hFFFF_FFF8, 8, 0, -1, '0, -1, '0, 1'b0, 1'b0,
            '{p: 1'b1, t: 1'b0, e: 16'd0, fb: 8'd0, fm: 16'h0000, dc: 0});

        // Reset mid-run after beat 4
        do_start(32'h5555_0000);
        for (int k = 0; k < 5; k++) begin
            dat = (k == 1) ? (gen_beat(32'h5555_0000, k) ^ ones) : gen_beat(32'h5555_0000, k);
            vld = 1'b1;
            @(negedge ui_clk);
        end
        vld = 1'b0;
        dat = '0;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        chk("pre_rst_err", {16'd0, err_cnt}, 32'd1);
        #2;
        ui_rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_err_cnt", {16'd0, err_cnt}, 32'd0);
        chk("arst_first_err_beat", {24'd0, first_err_beat}, 32'd0);
        chk("arst_first_err_mask", {16'd0, first_err_mask}, 32'd0);
        @(negedge ui_clk);
        ui_rst_n = 1'b1;
        @(negedge ui_clk);

        run(32'h0BAD_0000, 8, 0, -1, '0, -1, '0, 1'b0, 1'b0,
            '{p: 1'b1, t: 1'b0, e: 16'd0, fb: 8'd0, fm: 16'h0000, dc: 0});

        repeat (3) @(negedge ui_clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/ddr3_rd_checker.md
Name: ddr3_rd_checker

Overview:
Read-back checker sitting directly downstream of the DDR3 MIG user-interface test controller. It consumes the app_rd_data / app_rd_data_valid beat stream of one read burst sequence, regenerates the expected incrementing pattern from a seed, and compares lane by lane. It reports pass/fail, a saturating error count, the first failing beat with its lane mask, and a no-data timeout.

Parameters:
BEATS, 8, number of 512-bit read beats per check run (64-address window / 8 addresses per beat)
TIMEOUT_CYC, 4096, max ui_clk cycles allowed between start and first beat, or between consecutive beats
LANES, 16, number of 32-bit compare lanes in one 512-bit beat (fixed; DATA_W = 32*LANES)

Ports:
ui_clk  input  1  MIG user-interface clock; all logic on rising edge
ui_rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a run; honoured only in IDLE or DONE
seed  input  32  base pattern value; latched on accepted start
app_rd_data_valid  input  1  read beat qualifier from MIG
app_rd_data  input  512  read beat data from MIG
busy  output  1  high while in CHECK
done  output  1  high in DONE until next accepted start
pass  output  1  valid when done=1; 1 = all BEATS beats matched and no timeout
timeout  output  1  set when the run ended on TIMEOUT_CYC expiry
err_cnt  output  16  count of mismatching beats in the run, saturates at 16'hFFFF
first_err_beat  output  8  beat index (0-based) of first mismatching beat
first_err_mask  output  16  lane mismatch mask of first mismatching beat, bit i = lane i

Behaviour:
- Clocking/reset: one clock (ui_clk); reset asynchronous, active-low (ui_rst_n). On reset: state IDLE, busy=0, done=0, pass=0, timeout=0, err_cnt=0, first_err_beat=0, first_err_mask=0, beat counter=0, timeout counter=0, latched seed=0. Reset mid-run aborts the run with no report.
- States: IDLE, CHECK, DONE (one-hot).
- IDLE: app_rd_data_valid ignored. start=1 -> CHECK next edge; latch seed; clear err_cnt, first_err_*, timeout, pass, beat counter, timeout counter.
- CHECK: busy=1.
  - Expected lane i of beat k = seed + 16*k + i, modulo 2^32; lane i = app_rd_data[32i+31:32i].
  - Compare is combinational on the sampled beat; all result registers update on the same edge the beat is sampled (beat sampled at edge E -> err_cnt and state visible after E).
  - Mismatching beat: err_cnt += 1 (hold at 16'hFFFF). If first mismatch of the run, capture first_err_beat=k and first_err_mask; later mismatches do not overwrite them.
  - Each valid beat increments beat counter and clears timeout counter.
  - When beat k = BEATS-1 is sampled: -> DONE; pass = (no mismatch in any beat, including this one).
  - Without valid: timeout counter increments; on reaching TIMEOUT_CYC-1 -> DONE with timeout=1, pass=0; err_cnt/first_err_* keep values so far.
  - start in CHECK ignored.
- DONE: done=1, busy=0; results held stable; app_rd_data_valid ignored (stray beats not counted). start=1 -> CHECK with same clearing as from IDLE; done drops the edge after start.
- Simultaneous: valid with last beat and timeout expiry on the same cycle -> beat wins, timeout=0.
- No backpressure: checker accepts one beat every cycle valid is high.

Test Plan:
- Clean run: seed=32'h0000_0000, 8 consecutive beats with beat k lane i = 16k+i -> done one edge after 8th beat, pass=1, err_cnt=0, timeout=0.
- Single-lane error: seed=32'h1000_0000, beat 3 lane 5 corrupted (XOR 1) -> pass=0, err_cnt=1, first_err_beat=3, first_err_mask=16'h0020.
- Multiple errors: beats 2 and 6 fully inverted -> err_cnt=2, first_err_beat=2, first_err_mask=16'hFFFF, pass=0.
- Gapped stream/timeout: TIMEOUT_CYC=16, 4 beats with 3-cycle gaps then silence -> done 16 cycles after 4th beat, timeout=1, pass=0, err_cnt=0; repeat with 15-cycle gaps -> pass=1.
- Control robustness: start pulsed during CHECK and stray valid beats in IDLE/DONE -> no effect on counters; start in DONE with seed=32'hFFFF_FFF8 -> wrap expected values (beat 0 lane 8 = 0) pass=1.
- Reset: assert ui_rst_n=0 after beat 4 -> all outputs 0 immediately (asynchronous), state IDLE; fresh run afterwards passes.
